// File: rtl/div_8_pkg.sv
// div_8 shared types and constants.
// Imported by div_8 and div_8_step.
package div_8_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; 0x80 maps to 128 as unsigned.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_8_step.sv
// div_8 single restoring-division trial subtraction.
// Inverted-divisor add with carry-in; carry-out is the >=0 flag.
module div_8_step
  import div_8_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   diff,
  output logic             ge
);

  logic [WIDTH+1:0] sum;

  assign sum = {1'b0, rem}
             + {1'b0, ~{1'b0, dvs}}
             + {{(WIDTH+1){1'b0}}, 1'b1};

  assign diff = sum[WIDTH:0];
  assign ge   = sum[WIDTH+1];

endmodule

// File: rtl/div_8.sv
// div_8: multi-cycle 8-bit restoring divider, 9-cycle latency.
// Define DIV_8_SIGNED_EN for two's-complement operands.
module div_8
  import div_8_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  state_t state_q, state_d;

  logic [WIDTH:0]   r_q, r_sh, r_nx, diff;
  logic [WIDTH-1:0] q_q, d_q, q_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             ge, start, b_zero, last;

  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH-1:0] fin_q, fin_r;
  logic             fin_exc;

  logic [WIDTH-1:0] res_d, rem_d;
  logic             exc_d, rdy_d, busy_d;

  assign start  = ctrl_DIV && (state_q != RUN);
  assign b_zero = (data_operandB == '0);
  assign last   = (state_q == RUN) &&
                  (cnt_q == CNT_W'(WIDTH - 1));

  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_8_step u_step (
    .rem  (r_sh),
    .dvs  (d_q),
    .diff (diff),
    .ge   (ge)
  );

  assign r_nx = ge ? diff : r_sh;
  assign q_nx = {q_q[WIDTH-2:0], ge};

`ifdef DIV_8_SIGNED_EN
  logic neg_q_q, neg_r_q, ovf_q;

  assign a_in    = mag(data_operandA);
  assign b_in    = mag(data_operandB);
  assign fin_q   = neg_q_q ? (~q_nx + 1'b1) : q_nx;
  assign fin_r   = neg_r_q ? (~r_nx[WIDTH-1:0] + 1'b1)
                           : r_nx[WIDTH-1:0];
  assign fin_exc = ovf_q;

  // Sign bookkeeping captured with the operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      neg_q_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      neg_r_q <= data_operandA[WIDTH-1];
      ovf_q   <= (data_operandA == 8'h80) &&
                 (data_operandB == 8'hFF);
    end
  end
`else
  assign a_in    = data_operandA;
  assign b_in    = data_operandB;
  assign fin_q   = q_nx;
  assign fin_r   = r_nx[WIDTH-1:0];
  assign fin_exc = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_DIV) state_d = b_zero ? DONE : RUN;
        else          state_d = IDLE;
      end
      RUN:     if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    res_d  = data_result;
    rem_d  = data_remainder;
    exc_d  = data_exception;
    rdy_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
    if (start) begin
      exc_d = 1'b0;
      if (b_zero) begin
        res_d = '0;
        rem_d = '0;
        exc_d = 1'b1;
      end
    end
    if (last) begin
      res_d = fin_q;
      rem_d = fin_r;
      exc_d = fin_exc;
    end
  end

  // Shift/subtract datapath and iteration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      r_q   <= '0;
      q_q   <= a_in;
      d_q   <= b_in;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      r_q   <= r_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else begin
      data_result    <= res_d;
      data_remainder <= rem_d;
      data_exception <= exc_d;
      data_resultRDY <= rdy_d;
      data_busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_8.sv
// div_8 testbench: directed vector table, corner sequences,
// and a random sweep against an arithmetic model.
module tb_div_8;

  logic       clock = 1'b0;
  logic       reset;
  logic       ctrl_DIV;
  logic [7:0] opa, opb;
  logic [7:0] data_result, data_remainder;
  logic       data_exception, data_resultRDY, data_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       exc;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  div_8 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic start_now(input logic [7:0] a,
                           input logic [7:0] b);
    opa      = a;
    opb      = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    opa      = 8'($urandom);
    opb      = 8'($urandom);
  endtask

  task automatic start_div(input logic [7:0] a,
                           input logic [7:0] b);
    @(negedge clock);
    start_now(a, b);
  endtask

  task automatic wait_rdy(output int lat,
                          output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      if (!data_busy) busy_ok = 1'b0;
    end while (!data_resultRDY && lat < 20);
  endtask

  task automatic model(input  logic [7:0] a,
                       input  logic [7:0] b,
                       output logic [7:0] q,
                       output logic [7:0] r,
                       output logic       e);
`ifdef DIV_8_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (a == 8'h80 && b == 8'hFF) begin
      q = 8'h80;
      r = 8'h00;
      e = 1'b1;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      e = 1'b0;
    end
`else
    q = a / b;
    r = a % b;
    e = 1'b0;
`endif
  endtask

  initial begin
    int         lat;
    bit         bok;
    logic [7:0] ea, eb, eq, er;
    logic       ee;
    bit         rdy_seen, nonzero;

    tbl.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 9});
    tbl.push_back('{8'h2A, 8'h00, 8'h00, 8'h00, 1'b1, 1});
    tbl.push_back('{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9});
    tbl.push_back('{8'h05, 8'h0A, 8'h00, 8'h05, 1'b0, 9});
    tbl.push_back('{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 9});
    tbl.push_back('{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 9});
`ifdef DIV_8_SIGNED_EN
    tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9});
    tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 9});
    tbl.push_back('{8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0, 9});
    tbl.push_back('{8'hC8, 8'h0D, 8'hFC, 8'hFC, 1'b0, 9});
`else
    tbl.push_back('{8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0, 9});
    tbl.push_back('{8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9});
    tbl.push_back('{8'h80, 8'h03, 8'h2A, 8'h02, 1'b0, 9});
    tbl.push_back('{8'hC8, 8'h0D, 8'h0F, 8'h05, 1'b0, 9});
`endif

    reset    = 1'b1;
    ctrl_DIV = 1'b0;
    opa      = 8'h00;
    opb      = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out",
          {data_result, data_remainder, data_exception,
           data_resultRDY, data_busy}, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      start_div(tbl[i].a, tbl[i].b);
      wait_rdy(lat, bok);
      check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("v%0d_busy", i), bok, 1);
      check($sformatf("v%0d_q", i), data_result, tbl[i].q);
      check($sformatf("v%0d_r", i), data_remainder, tbl[i].r);
      check($sformatf("v%0d_exc", i), data_exception,
            tbl[i].exc);
      @(negedge clock);
      check($sformatf("v%0d_rdy_pulse", i),
            {data_resultRDY, data_busy}, 0);
      check($sformatf("v%0d_hold", i),
            {data_result, data_remainder, data_exception},
            {tbl[i].q, tbl[i].r, tbl[i].exc});
    end

    // Exception holds while idle, then clears on next start.
    start_div(8'h2A, 8'h00);
    wait_rdy(lat, bok);
    repeat (3) @(negedge clock);
    check("exc_hold", data_exception, 1);
    start_div(8'h64, 8'h07);
    @(negedge clock);
    check("exc_clear", data_exception, 0);
    wait_rdy(lat, bok);
    check("after_exc_lat", lat, 8);
    check("after_exc_q", data_result, 8'h0E);

    // Back-to-back start accepted in the DONE cycle.
    start_div(8'hFF, 8'h01);
    wait_rdy(lat, bok);
    check("b2b_first_lat", lat, 9);
    check("b2b_first_q", {data_result, data_remainder},
          16'hFF00);
    start_now(8'h05, 8'h0A);
    wait_rdy(lat, bok);
    check("b2b_second_lat", lat, 9);
    check("b2b_second_busy", bok, 1);
    check("b2b_second_q", {data_result, data_remainder},
          16'h0005);
    check("b2b_exc", data_exception, 0);

    // Ignored restart during RUN, then reset mid-flight.
    start_div(8'h64, 8'h07);
    rdy_seen = 1'b0;
    nonzero  = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen = 1'b1;
      if (c >= 7 && (data_result != 0 ||
          data_remainder != 0 || data_exception ||
          data_busy)) nonzero = 1'b1;
      if (c == 4) begin
        ctrl_DIV = 1'b1;
        opa      = 8'h10;
        opb      = 8'h02;
      end
      if (c == 5) ctrl_DIV = 1'b0;
      if (c == 6) reset = 1'b1;
      if (c == 7) reset = 1'b0;
    end
    check("rst_no_rdy", rdy_seen, 0);
    check("rst_outputs_zero", nonzero, 0);

    // Random sweep with nonzero divisors.
    for (int k = 0; k < 1500; k++) begin
      ea = 8'($urandom);
      eb = 8'($urandom_range(1, 255));
      if (k == 0) begin
        ea = 8'h80;
        eb = 8'hFF;
      end
      model(ea, eb, eq, er, ee);
      start_div(ea, eb);
      wait_rdy(lat, bok);
      check($sformatf("rnd_%0h_%0h", ea, eb),
            {lat[7:0], data_result, data_remainder,
             data_exception},
            {8'd9, eq, er, ee});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
